// File: rtl/ps2_keypad_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ps2_keypad_ctrl
// Brief    : PS/2 scan-code command controller. Follows the make / break /
//            extended-prefix protocol, builds a BCD entry from digit keys
//            and commits it as the alarm setpoint on Enter.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_keypad_ctrl #(
  parameter int NDIG        = 4,        // BCD digits in entry / setpoint (2..7)
  parameter int TIMEOUT_CYC = 1000000,  // idle cycles before a prefix is dropped
  parameter int CW          = 20        // timeout counter width
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_tick,
  input  logic [7:0]          i_dato,
  input  logic                i_correct,
  output logic [4*NDIG-1:0]   o_entry,
  output logic [2:0]          o_entry_cnt,
  output logic [4*NDIG-1:0]   o_setpoint,
  output logic                o_setpoint_valid,
  output logic                o_commit,
  output logic                o_err
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_BRK     = 2'd1;
  localparam logic [1:0] c_EXT     = 2'd2;
  localparam logic [1:0] c_EXT_BRK = 2'd3;

  localparam logic [7:0]    c_BREAK   = 8'hF0;
  localparam logic [7:0]    c_EXTEND  = 8'hE0;
  localparam logic [7:0]    c_ENTER   = 8'h5A;
  localparam logic [7:0]    c_DELETE  = 8'h71;
  localparam logic [7:0]    c_BKSP    = 8'h66;
  localparam logic [7:0]    c_ESC     = 8'h76;
  localparam logic [2:0]    c_NDIG    = 3'(NDIG);
  localparam logic [CW-1:0] c_TO_LAST = CW'(TIMEOUT_CYC - 1);

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [CW-1:0]       r_to_cnt;
  logic [4*NDIG-1:0]   r_entry;
  logic [2:0]          r_entry_cnt;
  logic [4*NDIG-1:0]   r_setpoint;
  logic                r_setpoint_valid;
  logic                r_commit;
  logic                r_err;

  logic                w_valid;
  logic                w_bad;
  logic                w_act_digit;
  logic                w_act_bksp;
  logic                w_act_clear;
  logic                w_act_enter;
  logic [3:0]          w_digit;

  assign w_valid = i_tick & i_correct;
  assign w_bad   = i_tick & ~i_correct;

  // Protocol state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next protocol state: bytes drive transitions, an idle prefix times out
  always_comb begin
    w_state_nxt = r_state;
    if (w_bad) begin
      w_state_nxt = c_IDLE;
    end else if (w_valid) begin
      case (r_state)
        c_IDLE: begin
          if (i_dato == c_BREAK)       w_state_nxt = c_BRK;
          else if (i_dato == c_EXTEND) w_state_nxt = c_EXT;
          else                         w_state_nxt = c_IDLE;
        end
        c_EXT: begin
          if (i_dato == c_BREAK) w_state_nxt = c_EXT_BRK;
          else                   w_state_nxt = c_IDLE;
        end
        default: w_state_nxt = c_IDLE;  // BRK / EXT_BRK swallow the released key
      endcase
    end else if (r_state != c_IDLE && r_to_cnt == c_TO_LAST) begin
      w_state_nxt = c_IDLE;
    end
  end

  // Key action decode for the byte consumed this cycle
  always_comb begin
    w_act_digit = 1'b0;
    w_act_bksp  = 1'b0;
    w_act_clear = 1'b0;
    w_act_enter = 1'b0;
    w_digit     = 4'd0;
    if (w_valid && r_state == c_IDLE) begin
      case (i_dato)
        8'h45: begin w_act_digit = 1'b1; w_digit = 4'd0; end
        8'h16: begin w_act_digit = 1'b1; w_digit = 4'd1; end
        8'h1E: begin w_act_digit = 1'b1; w_digit = 4'd2; end
        8'h26: begin w_act_digit = 1'b1; w_digit = 4'd3; end
        8'h25: begin w_act_digit = 1'b1; w_digit = 4'd4; end
        8'h2E: begin w_act_digit = 1'b1; w_digit = 4'd5; end
        8'h36: begin w_act_digit = 1'b1; w_digit = 4'd6; end
        8'h3D: begin w_act_digit = 1'b1; w_digit = 4'd7; end
        8'h3E: begin w_act_digit = 1'b1; w_digit = 4'd8; end
        8'h46: begin w_act_digit = 1'b1; w_digit = 4'd9; end
        c_BKSP:  w_act_bksp  = 1'b1;
        c_ESC:   w_act_clear = 1'b1;
        c_ENTER: w_act_enter = 1'b1;
        default: ;
      endcase
    end else if (w_valid && r_state == c_EXT) begin
      if (i_dato == c_ENTER)  w_act_enter = 1'b1;
      if (i_dato == c_DELETE) w_act_clear = 1'b1;
    end
  end

  // Prefix timeout counter: runs only while a prefix is pending and idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_to_cnt <= '0;
    else if (i_tick || w_state_nxt == c_IDLE) r_to_cnt <= '0;
    else                                    r_to_cnt <= r_to_cnt + 1'b1;
  end

  // Entry buffer, setpoint and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_entry          <= '0;
      r_entry_cnt      <= 3'd0;
      r_setpoint       <= '0;
      r_setpoint_valid <= 1'b0;
      r_commit         <= 1'b0;
      r_err            <= 1'b0;
    end else begin
      r_commit <= 1'b0;
      if (w_bad) r_err <= 1'b1;
      if (w_act_digit && r_entry_cnt < c_NDIG) begin
        r_entry     <= {r_entry[4*NDIG-5:0], w_digit};
        r_entry_cnt <= r_entry_cnt + 3'd1;
      end
      if (w_act_bksp && r_entry_cnt != 3'd0) begin
        r_entry     <= r_entry >> 4;
        r_entry_cnt <= r_entry_cnt - 3'd1;
      end
      if (w_act_clear) begin
        r_entry     <= '0;
        r_entry_cnt <= 3'd0;
        r_err       <= 1'b0;
      end
      // An Enter on an empty buffer is a no-op, including for err
      if (w_act_enter && r_entry_cnt != 3'd0) begin
        r_setpoint       <= r_entry;
        r_setpoint_valid <= 1'b1;
        r_commit         <= 1'b1;
        r_entry          <= '0;
        r_entry_cnt      <= 3'd0;
        r_err            <= 1'b0;
      end
    end
  end

  assign o_entry          = r_entry;
  assign o_entry_cnt      = r_entry_cnt;
  assign o_setpoint       = r_setpoint;
  assign o_setpoint_valid = r_setpoint_valid;
  assign o_commit         = r_commit;
  assign o_err            = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keypad_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_keypad_ctrl
// Brief    : Self-checking bench for ps2_keypad_ctrl against a keystroke-level
//            reference model (digit queue plus pending-prefix flags).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_keypad_ctrl;

  localparam int NDIG = 4;
  localparam int TO   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_tick = 1'b0;
  logic [7:0]  i_dato = 8'h00;
  logic        i_correct = 1'b0;
  logic [15:0] o_entry;
  logic [2:0]  o_entry_cnt;
  logic [15:0] o_setpoint;
  logic        o_setpoint_valid;
  logic        o_commit;
  logic        o_err;

  int n_vec = 0;
  int n_err = 0;

  ps2_keypad_ctrl #(.NDIG(NDIG), .TIMEOUT_CYC(TO), .CW(5)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_tick           (i_tick),
    .i_dato           (i_dato),
    .i_correct        (i_correct),
    .o_entry          (o_entry),
    .o_entry_cnt      (o_entry_cnt),
    .o_setpoint       (o_setpoint),
    .o_setpoint_valid (o_setpoint_valid),
    .o_commit         (o_commit),
    .o_err            (o_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [3:0]  q[$];           // typed digits, q[0] = most recent
  bit          rel_p, ext_p;   // key-release pending, extended prefix pending
  int          idle_n;
  logic [15:0] m_setpoint;
  bit          m_valid, m_commit, m_err;
  logic [7:0]  codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                              8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  function automatic logic [15:0] m_entry();
    logic [15:0] v = '0;
    for (int i = 0; i < q.size(); i++) v[4*i +: 4] = q[i];
    return v;
  endfunction

  function automatic logic [37:0] m_vec();
    return {m_entry(), 3'(q.size()), m_setpoint, m_valid, m_commit, m_err};
  endfunction

  function automatic logic [37:0] d_vec();
    return {o_entry, o_entry_cnt, o_setpoint, o_setpoint_valid, o_commit, o_err};
  endfunction

  task automatic model_reset();
    q.delete(); rel_p = 0; ext_p = 0; idle_n = 0;
    m_setpoint = '0; m_valid = 0; m_commit = 0; m_err = 0;
  endtask

  task automatic model_enter();
    if (q.size() > 0) begin
      m_setpoint = m_entry(); m_valid = 1; m_commit = 1; m_err = 0; q.delete();
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok);
    m_commit = 0;
    idle_n   = 0;
    if (!ok) begin
      m_err = 1; rel_p = 0; ext_p = 0;
    end else if (rel_p) begin
      rel_p = 0; ext_p = 0;
    end else if (ext_p) begin
      ext_p = 0;
      if (b == 8'hF0)      rel_p = 1;
      else if (b == 8'h5A) model_enter();
      else if (b == 8'h71) begin q.delete(); m_err = 0; end
    end else begin
      if (b == 8'hF0)      rel_p = 1;
      else if (b == 8'hE0) ext_p = 1;
      else if (b == 8'h5A) model_enter();
      else if (b == 8'h76) begin q.delete(); m_err = 0; end
      else if (b == 8'h66) begin if (q.size() > 0) void'(q.pop_front()); end
      else begin
        for (int d = 0; d < 10; d++)
          if (codes[d] == b && q.size() < NDIG) q.push_front(4'(d));
      end
    end
  endtask

  task automatic model_idle();
    m_commit = 0;
    if (rel_p || ext_p) begin
      idle_n++;
      if (idle_n >= TO) begin rel_p = 0; ext_p = 0; idle_n = 0; end
    end
  endtask

  // ---------------- drivers (called at a falling edge) ----------------
  task automatic send(input logic [7:0] b, input bit ok = 1'b1);
    i_tick = 1'b1; i_dato = b; i_correct = ok;
    @(negedge clk);
    i_tick = 1'b0; i_correct = 1'b0;
    model_byte(b, ok);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); model_idle(); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    send(8'h1E); send(8'hF0);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (d_vec() !== 38'h0) begin
      n_err++; $display("FAIL reset_async: got %h exp 0", d_vec());
    end
    @(negedge clk); rst = 1'b0; model_reset();
    @(negedge clk);
    send(8'h16);
    n_vec++;
    if (o_entry !== 16'h0001 || o_entry_cnt !== 3'd1) begin
      n_err++; $display("FAIL reset_then_make: got %h/%0d exp 0001/1", o_entry, o_entry_cnt);
    end
  endtask

  task automatic test_entry_commit();
    logic [7:0] seq [9] = '{8'h16, 8'hF0, 8'h16, 8'h1E, 8'hF0, 8'h1E, 8'h45, 8'hF0, 8'h45};
    send(8'h76);
    foreach (seq[i]) send(seq[i]);
    n_vec++;
    if (o_entry !== 16'h0120 || o_entry_cnt !== 3'd3) begin
      n_err++; $display("FAIL entry_0120: got %h/%0d exp 0120/3", o_entry, o_entry_cnt);
    end
    send(8'h5A);
    n_vec++;
    if (d_vec() !== {16'h0, 3'd0, 16'h0120, 1'b1, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL commit_0120: got %h exp %h", d_vec(), {16'h0, 3'd0, 16'h0120, 3'b110});
    end
    idle(1);
    n_vec++;
    if (o_commit !== 1'b0 || o_setpoint !== 16'h0120) begin
      n_err++; $display("FAIL commit_one_cycle: got %b/%h exp 0/0120", o_commit, o_setpoint);
    end
  endtask

  task automatic test_saturation_backspace();
    logic [7:0] seq [5] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
    foreach (seq[i]) send(seq[i]);
    n_vec++;
    if (o_entry !== 16'h1234 || o_entry_cnt !== 3'd4) begin
      n_err++; $display("FAIL saturate: got %h/%0d exp 1234/4", o_entry, o_entry_cnt);
    end
    send(8'h66);
    n_vec++;
    if (o_entry !== 16'h0123 || o_entry_cnt !== 3'd3) begin
      n_err++; $display("FAIL backspace: got %h/%0d exp 0123/3", o_entry, o_entry_cnt);
    end
    send(8'h76);
    n_vec++;
    if (o_entry !== 16'h0 || o_entry_cnt !== 3'd0) begin
      n_err++; $display("FAIL esc_clear: got %h/%0d exp 0/0", o_entry, o_entry_cnt);
    end
    send(8'h66);
    n_vec++;
    if (d_vec() !== m_vec()) begin
      n_err++; $display("FAIL backspace_empty: got %h exp %h", d_vec(), m_vec());
    end
  endtask

  task automatic test_break_ext();
    send(8'h3D);
    send(8'hF0); send(8'h5A);
    n_vec++;
    if (o_commit !== 1'b0 || o_entry !== 16'h0007) begin
      n_err++; $display("FAIL break_enter: got %b/%h exp 0/0007", o_commit, o_entry);
    end
    send(8'hE0); send(8'hF0); send(8'h5A);
    n_vec++;
    if (o_commit !== 1'b0 || o_entry !== 16'h0007) begin
      n_err++; $display("FAIL ext_break_enter: got %b/%h exp 0/0007", o_commit, o_entry);
    end
    send(8'hE0); send(8'h5A);
    n_vec++;
    if (o_commit !== 1'b1 || o_setpoint !== 16'h0007 || o_entry_cnt !== 3'd0) begin
      n_err++; $display("FAIL kp_enter: got %b/%h/%0d exp 1/0007/0", o_commit, o_setpoint, o_entry_cnt);
    end
    send(8'h16); send(8'h1E); send(8'hE0); send(8'h71);
    n_vec++;
    if (o_entry !== 16'h0 || o_entry_cnt !== 3'd0 || o_setpoint !== 16'h0007) begin
      n_err++; $display("FAIL ext_delete: got %h/%0d/%h exp 0/0/0007", o_entry, o_entry_cnt, o_setpoint);
    end
  endtask

  task automatic test_bad_frame();
    send(8'h26);
    send(8'h16, 1'b0);
    n_vec++;
    if (o_err !== 1'b1 || o_entry !== 16'h0003) begin
      n_err++; $display("FAIL bad_frame: got %b/%h exp 1/0003", o_err, o_entry);
    end
    send(8'hE0); send(8'h5A, 1'b0); send(8'h16);
    n_vec++;
    if (o_entry !== 16'h0031 || o_err !== 1'b1) begin
      n_err++; $display("FAIL bad_frame_idle: got %h/%b exp 0031/1", o_entry, o_err);
    end
    send(8'h76);
    n_vec++;
    if (o_err !== 1'b0 || o_entry !== 16'h0) begin
      n_err++; $display("FAIL esc_clears_err: got %b/%h exp 0/0", o_err, o_entry);
    end
  endtask

  task automatic test_timeout();
    send(8'hF0); idle(16); send(8'h1E);
    n_vec++;
    if (o_entry !== 16'h0002 || o_entry_cnt !== 3'd1) begin
      n_err++; $display("FAIL timeout_16: got %h/%0d exp 0002/1", o_entry, o_entry_cnt);
    end
    send(8'h76);
    send(8'hF0); idle(10); send(8'h1E);
    n_vec++;
    if (o_entry !== 16'h0 || o_entry_cnt !== 3'd0) begin
      n_err++; $display("FAIL timeout_10: got %h/%0d exp 0/0", o_entry, o_entry_cnt);
    end
    // a tick inside the prefix restarts the wait
    send(8'hE0); idle(10); send(8'hF0); idle(10); send(8'h1E);
    n_vec++;
    if (o_entry !== 16'h0 || o_entry_cnt !== 3'd0) begin
      n_err++; $display("FAIL timeout_restart: got %h/%0d exp 0/0", o_entry, o_entry_cnt);
    end
    send(8'hE0); idle(20); send(8'h45);
    n_vec++;
    if (o_entry_cnt !== 3'd1 || d_vec() !== m_vec()) begin
      n_err++; $display("FAIL timeout_ext: got %h exp %h", d_vec(), m_vec());
    end
  endtask

  task automatic test_back_to_back();
    send(8'h76); send(8'h5A); send(8'h5A);
    n_vec++;
    if (o_commit !== 1'b0) begin
      n_err++; $display("FAIL empty_enter: got %b exp 0", o_commit);
    end
    send(8'h16); send(8'h5A);
    n_vec++;
    if (o_commit !== 1'b1 || o_setpoint !== 16'h0001) begin
      n_err++; $display("FAIL enter_first: got %b/%h exp 1/0001", o_commit, o_setpoint);
    end
    send(8'h5A);
    n_vec++;
    if (o_commit !== 1'b0 || o_setpoint !== 16'h0001) begin
      n_err++; $display("FAIL enter_second: got %b/%h exp 0/0001", o_commit, o_setpoint);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [8] = '{8'hF0, 8'hE0, 8'h66, 8'h76, 8'h5A, 8'h71, 8'h5A, 8'h00};
    logic [7:0] b;
    int         gap;
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 1) == 0) b = codes[$urandom_range(0, 9)];
      else if ($urandom_range(0, 7) == 0) b = 8'($urandom);
      else b = pool[$urandom_range(0, 6)];
      send(b, $urandom_range(0, 15) != 0);
      n_vec++;
      if (d_vec() !== m_vec()) begin
        n_err++; $display("FAIL random_byte[%0d] %h: got %h exp %h", it, b, d_vec(), m_vec());
      end
      case ($urandom_range(0, 9))
        0, 1:    gap = $urandom_range(1, 4);
        2:       gap = $urandom_range(12, 20);
        default: gap = 0;
      endcase
      if (gap > 0) begin
        idle(gap);
        n_vec++;
        if (d_vec() !== m_vec()) begin
          n_err++; $display("FAIL random_idle[%0d]: got %h exp %h", it, d_vec(), m_vec());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    #22 rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (d_vec() !== 38'h0) begin
      n_err++; $display("FAIL reset_state: got %h exp 0", d_vec());
    end
    test_reset();
    test_entry_commit();
    test_saturation_backspace();
    test_break_ext();
    test_bad_frame();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/ps2_keypad_ctrl.md
Name: ps2_keypad_ctrl

Overview:
- Command controller between the PS/2 byte receiver and the display/fan-alarm subsystem.
- Consumes the receiver's per-byte strobe, scan-code byte and frame-valid flag.
- Tracks the make/break/extended-prefix protocol and builds a multi-digit decimal entry from keystrokes.
- Commits that entry as the alarm setpoint on Enter; the entry and setpoint feed the seven-segment display and alarm comparator.

Parameters:
- NDIG, 4, number of BCD digits in the entry buffer and setpoint.
- TIMEOUT_CYC, 1000000, idle cycles after a prefix byte (F0/E0) before the prefix is abandoned.
- CW, 20, width of the timeout counter; must satisfy 2^CW > TIMEOUT_CYC.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  reset, asynchronous, active-high.
- tick  input  1  one-cycle strobe from receiver; dato and correct are valid in that cycle.
- dato  input  8  received scan-code byte.
- correct  input  1  frame/parity valid for the byte strobed by tick.
- entry  output  4*NDIG  BCD entry buffer; digit 0 (most recently typed) in bits [3:0].
- entry_cnt  output  3  number of digits currently held, 0..NDIG.
- setpoint  output  4*NDIG  last committed BCD value.
- setpoint_valid  output  1  sticky; set by the first commit.
- commit  output  1  one-cycle pulse when setpoint is loaded.
- err  output  1  sticky error flag for a bad frame.

Behaviour:
- Reset (async, rst=1): all outputs 0, FSM in IDLE, timeout counter 0. Reset mid-sequence discards any pending prefix.
- A byte is consumed only in a cycle with tick=1. All outputs are registered and update on the clock edge ending that cycle (latency 1).
- If tick=1 and correct=0: the byte is discarded, err<=1, FSM->IDLE, entry unchanged.
- FSM states: IDLE, BRK, EXT, EXT_BRK.
  - IDLE: F0 -> BRK; E0 -> EXT; any other byte is treated as a make code (see key actions).
  - BRK: next valid byte discarded (key release) -> IDLE.
  - EXT: F0 -> EXT_BRK; 5A (keypad Enter) -> Enter action, IDLE; 71 (Delete) -> Clear action, IDLE; any other byte ignored -> IDLE.
  - EXT_BRK: next valid byte discarded -> IDLE.
- Timeout:
  - In BRK/EXT/EXT_BRK, the counter increments each cycle without tick and clears on every tick or on entry to IDLE.
  - When the counter reaches TIMEOUT_CYC-1 the FSM returns to IDLE with no other effect.
  - The counter holds 0 in IDLE.
- Key actions (IDLE make codes):
  - Digits 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9. If entry_cnt<NDIG: entry<={entry[4*NDIG-5:0],digit}, entry_cnt+1. If entry_cnt==NDIG the digit is ignored and nothing changes.
  - 66 Backspace: if entry_cnt>0, entry<=entry>>4 (zero-fill top) and entry_cnt-1; otherwise no change.
  - 76 Esc / Clear: entry<=0, entry_cnt<=0, err<=0.
  - 5A Enter: if entry_cnt>0, then setpoint<=entry, setpoint_valid<=1, commit=1 for one cycle, entry<=0, entry_cnt<=0, err<=0. If entry_cnt==0, Enter is ignored and commit stays 0.
  - All other bytes are ignored.
- Typematic repeat (repeated make codes without break) is treated as repeated keystrokes.
- commit is high only in the cycle after the Enter byte; back-to-back Enter bytes with an empty buffer produce no pulse.
- setpoint holds its value until the next successful commit and is unaffected by Esc or err.

Test Plan:
- Reset check: rst pulsed asynchronously mid-cycle -> all outputs 0 immediately; the following tick with 16 is treated as a make code (entry=0x0001, entry_cnt=1).
- Entry and commit: send 16,F0,16,1E,F0,1E,45,F0,45,5A -> entry 0x0120 before Enter. One cycle after 5A: setpoint=0x0120, commit=1 for exactly one cycle, setpoint_valid=1, entry=0, entry_cnt=0.
- Saturation and backspace: digits 1,2,3,4,5 (make codes only) -> entry=0x1234, cnt=4 (5 ignored). Then 66 -> entry=0x0123, cnt=3. Then 76 -> entry=0, cnt=0.
- Break and extended codes: F0,5A -> no commit. E0,F0,5A -> no commit. With entry=0x0007, E0,5A -> commit, setpoint=0x0007. E0,71 with cnt=2 -> entry cleared.
- Bad frame: tick with correct=0, dato=16 -> err=1, entry unchanged. Then E0 followed by a bad frame -> FSM IDLE (next 16 is accepted as a digit). Then 76 -> err=0.
- Timeout: with TIMEOUT_CYC=16, send F0 and wait 16 cycles without tick, then send 1E -> digit 2 entered. Same sequence with a 10-cycle wait -> 1E discarded as a break.
